// File: rtl/lbox_scheduler_if.sv
// Handshake bundle between the Clyde round controller, the L-box scheduler
// and the linear-layer datapath.
interface lbox_scheduler_if;
    localparam int unsigned STATE_W = 128;

    logic               in_valid;
    logic               in_ready;
    logic [STATE_W-1:0] in_state;
    logic               out_valid;
    logic               out_ready;
    logic [STATE_W-1:0] out_state;
    logic               busy;

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/lbox_scheduler.sv
// Time-multiplexes the Clyde-128 L-box over the four-word state: pair (w0,w1)
// then pair (w2,w3), or both at once when two L-box instances are present.
module lbox_scheduler #(
    parameter int unsigned NUM_LB  = 1,
    parameter int unsigned OUT_REG = 1
) (
    input  logic            clk,
    input  logic            rst,
    lbox_scheduler_if.slave bus
);
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned PAIR_W  = 2 * WORD_W;
    localparam int unsigned STATE_W = 4 * WORD_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_e;

    if (NUM_LB != 1 && NUM_LB != 2) begin : g_bad_num_lb
        $error("lbox_scheduler: NUM_LB must be 1 or 2");
    end
    if (OUT_REG != 1) begin : g_bad_out_reg
        $error("lbox_scheduler: OUT_REG must be 1");
    end

    function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] v,
                                               input int unsigned   n);
        return (v << n) | (v >> (WORD_W - n));
    endfunction

    function automatic logic [PAIR_W-1:0] lbox(input logic [WORD_W-1:0] x,
                                               input logic [WORD_W-1:0] y);
        logic [WORD_W-1:0] tx, ty, a3, b3, c, d;
        tx = x ^ rotl(x, 12);
        ty = y ^ rotl(y, 12);
        a3 = tx ^ rotl(tx, 3) ^ rotl(x, 17);
        b3 = ty ^ rotl(ty, 3) ^ rotl(y, 17);
        c  = a3 ^ rotl(a3, 31);
        d  = b3 ^ rotl(b3, 31);
        return {a3 ^ rotl(d, 26) ^ rotl(c, 15), b3 ^ rotl(c, 25) ^ rotl(d, 15)};
    endfunction

    state_e             state_q, state_d;
    logic [STATE_W-1:0] st_q, st_d;
    logic [STATE_W-1:0] res_q, res_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic               sel_hi_c;
    logic [PAIR_W-1:0]  lb_a_c;
    logic [PAIR_W-1:0]  lb_b_c;

    // Shared instance: pair select is driven by the state register alone.
    assign sel_hi_c = (state_q == S_HI);
    assign lb_a_c   = lbox(sel_hi_c ? st_q[63:32] : st_q[127:96],
                           sel_hi_c ? st_q[31:0]  : st_q[95:64]);

    if (NUM_LB == 2) begin : g_dual
        assign lb_b_c = lbox(st_q[63:32], st_q[31:0]);
    end else begin : g_single
        assign lb_b_c = '0;
    end

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        res_d   = res_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    st_d    = bus.in_state;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (NUM_LB == 2) begin
                    res_d   = {lb_a_c, lb_b_c};
                    state_d = S_DONE;
                end else begin
                    res_d[STATE_W-1:PAIR_W] = lb_a_c;
                    state_d                 = S_HI;
                end
            end
            S_HI: begin
                res_d[PAIR_W-1:0] = lb_a_c;
                state_d           = S_DONE;
            end
            S_DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    // Reset wins over any handshake on the same edge and discards partial results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            st_q        <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            res_q       <= res_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = res_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_lbox_scheduler.sv
// Bench for lbox_scheduler: NUM_LB=1 and NUM_LB=2 instances share one stimulus
// stream, each checked every cycle against a transaction-level reference model.
module tb_lbox_scheduler;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_state;
    logic         out_ready;

    logic         in_ready_w  [2];
    logic         out_valid_w [2];
    logic         busy_w      [2];
    logic [127:0] out_state_w [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lbox_scheduler_if bus [2] ();

    function automatic logic [31:0] rl(input logic [31:0] v, input int n);
        logic [63:0] t;
        t = {v, v} << n;
        return t[63:32];
    endfunction

    function automatic logic [63:0] ref_pair(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] a3, b3, c, d;
        a3 = x ^ rl(x, 12) ^ rl(x ^ rl(x, 12), 3) ^ rl(x, 17);
        b3 = y ^ rl(y, 12) ^ rl(y ^ rl(y, 12), 3) ^ rl(y, 17);
        c  = a3 ^ rl(a3, 31);
        d  = b3 ^ rl(b3, 31);
        return {a3 ^ rl(d, 26) ^ rl(c, 15), b3 ^ rl(c, 25) ^ rl(d, 15)};
    endfunction

    function automatic logic [127:0] ref_state(input logic [127:0] s);
        return {ref_pair(s[127:96], s[95:64]), ref_pair(s[63:32], s[31:0])};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string nm, input int id, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, id, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input int id, input logic act, input logic exp);
        chk(nm, id, 128'(act), 128'(exp));
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int LAT = (k == 0) ? 3 : 2;

        assign bus[k].in_valid  = in_valid;
        assign bus[k].in_state  = in_state;
        assign bus[k].out_ready = out_ready;
        assign in_ready_w[k]    = bus[k].in_ready;
        assign out_valid_w[k]   = bus[k].out_valid;
        assign busy_w[k]        = bus[k].busy;
        assign out_state_w[k]   = bus[k].out_state;

        lbox_scheduler #(.NUM_LB(k + 1), .OUT_REG(1)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus[k])
        );

        // Transaction model: one state in flight, result due LAT cycles after the accept cycle.
        bit           armed  = 1'b0;
        bit           m_busy = 1'b0;
        bit           m_valid = 1'b0;
        bit           m_zero = 1'b1;
        int           m_wait = 0;
        logic [127:0] m_exp  = '0;
        int           acc    = 0;

        always @(negedge clk) begin
            if (armed) begin
                chk1("in_ready", k, in_ready_w[k], !m_busy);
                chk1("busy", k, busy_w[k], m_busy);
                chk1("out_valid", k, out_valid_w[k], m_valid);
                if (m_valid)      chk("out_state", k, out_state_w[k], m_exp);
                else if (m_zero)  chk("out_state_zero", k, out_state_w[k], '0);
            end
            if (rst) begin
                armed   = 1'b1;
                m_busy  = 1'b0;
                m_valid = 1'b0;
                m_zero  = 1'b1;
                m_wait  = 0;
            end else if (!m_busy) begin
                if (in_valid) begin
                    m_busy = 1'b1;
                    m_wait = LAT - 1;
                    m_exp  = ref_state(in_state);
                    m_zero = 1'b0;
                    acc++;
                end
            end else if (!m_valid) begin
                m_wait--;
                if (m_wait == 0) m_valid = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
                m_busy  = 1'b0;
            end
        end
    end

    // One accept with out_ready=1; returns each DUT's result and cycles from accept cycle to out_valid.
    task automatic run_one(input logic [127:0] s, output logic [127:0] o0, output logic [127:0] o1,
                           output int l0, output int l1);
        o0 = '0; o1 = '0; l0 = 0; l1 = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_state  = s;
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                in_valid = 1'b0;
                in_state = rand128();
            end
            if (out_valid_w[0] && l0 == 0) begin l0 = n; o0 = out_state_w[0]; end
            if (out_valid_w[1] && l1 == 0) begin l1 = n; o1 = out_state_w[1]; end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] o0, o1, a0, a1, b0, b1, c0, c1, s1, s2, t2_in, t2_exp, pat;
        int l0, l1, base, cyc, waited;

        t2_in  = {32'h1, 32'h0, 32'h1, 32'h0};
        t2_exp = {32'hEC045008, 32'h1B0007B0, 32'hEC045008, 32'h1B0007B0};

        rst = 1'b1; in_valid = 1'b0; in_state = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk1("rst_in_ready", k, in_ready_w[k], 1'b1);
            chk1("rst_out_valid", k, out_valid_w[k], 1'b0);
            chk1("rst_busy", k, busy_w[k], 1'b0);
            chk("rst_out_state", k, out_state_w[k], '0);
        end
        rst = 1'b0;

        // Pin the reference model to hand-derived vectors.
        chk("model_t2", 0, ref_state(t2_in), t2_exp);
        chk("model_y1", 0, 128'(ref_pair(32'h0, 32'h1)), 128'({32'h36000F60, 32'hEC045008}));

        // T1: zero state and latency
        run_one('0, o0, o1, l0, l1);
        chk("t1_out", 0, o0, '0);
        chk("t1_out", 1, o1, '0);
        chk("t1_lat", 0, 128'(l0), 128'(3));
        chk("t1_lat", 1, 128'(l1), 128'(2));

        // T2 and further literal vectors (pair independence)
        run_one(t2_in, o0, o1, l0, l1);
        chk("t2_out", 0, o0, t2_exp);
        chk("t2_out", 1, o1, t2_exp);
        pat = {32'h0, 32'h1, 32'h0, 32'h1};
        run_one(pat, o0, o1, l0, l1);
        chk("y1_out", 0, o0, {32'h36000F60, 32'hEC045008, 32'h36000F60, 32'hEC045008});
        chk("y1_out", 1, o1, {32'h36000F60, 32'hEC045008, 32'h36000F60, 32'hEC045008});
        pat = {32'h1, 32'h0, 32'h0, 32'h1};
        run_one(pat, o0, o1, l0, l1);
        chk("mix_out", 0, o0, {32'hEC045008, 32'h1B0007B0, 32'h36000F60, 32'hEC045008});

        // T3: back-pressure in DONE
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_state  = t2_in;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_state = rand128();
        waited = 0;
        while (!out_valid_w[0] && waited < 8) begin
            @(posedge clk); #1;
            waited++;
        end
        chk1("t3_reached_done", 0, out_valid_w[0], 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                chk1("t3_hold_valid", k, out_valid_w[k], 1'b1);
                chk1("t3_hold_in_ready", k, in_ready_w[k], 1'b0);
                chk("t3_hold_state", k, out_state_w[k], t2_exp);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            chk1("t3_drained", k, out_valid_w[k], 1'b0);
            chk1("t3_in_ready", k, in_ready_w[k], 1'b1);
        end

        // T4: reset while NUM_LB=1 instance is in HI
        in_valid = 1'b1;
        in_state = rand128();
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk1("t4_out_valid", k, out_valid_w[k], 1'b0);
            chk1("t4_in_ready", k, in_ready_w[k], 1'b1);
            chk("t4_out_state", k, out_state_w[k], '0);
        end
        run_one(t2_in, o0, o1, l0, l1);
        chk("t4_after", 0, o0, t2_exp);
        chk("t4_after_lat", 0, 128'(l0), 128'(3));

        // T5: back-to-back random traffic with random back-pressure
        base = g_dut[0].acc;
        in_valid = 1'b1;
        cyc = 0;
        while (g_dut[0].acc < base + 1000 && cyc < 20000) begin
            in_state  = rand128();
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cyc++;
        end
        chk1("t5_completed", 0, (g_dut[0].acc >= base + 1000), 1'b1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        // T6: linearity
        for (int i = 0; i < 100; i++) begin
            s1 = rand128();
            s2 = rand128();
            run_one(s1, a0, a1, l0, l1);
            run_one(s2, b0, b1, l0, l1);
            run_one(s1 ^ s2, c0, c1, l0, l1);
            chk("t6_linear", 0, c0, a0 ^ b0);
            chk("t6_linear", 1, c1, a1 ^ b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
